mul_share_ctrl: RTL and testbench
=================================

Name: mul_share_ctrl

Overview:
- Sequencing controller and round-robin arbiter that shares one bit-serial 16x16 shift-add multiplier core between N_REQ requesters.
- Captures the winning requester's operands, loads them into the core, and clock-enables the core for exactly WIDTH cycles.
- Registers the truncated product and overflow flag, then returns them to the winner with a one-cycle acknowledge.
- Sits between the requesting datapath blocks and the multiplier core.

Parameters:
N_REQ, 4, number of requesters (2..8)
WIDTH, 16, operand/result width; also the number of RUN cycles
CNT_W, $clog2(WIDTH)+1, width of the RUN cycle counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
req_i  in  N_REQ  request per requester; level, held until ack
a_i  in  N_REQ*WIDTH  operand A per requester, slice k = [k*WIDTH +: WIDTH]
b_i  in  N_REQ*WIDTH  operand B per requester
gnt_o  out  N_REQ  one-hot owner of the multiplier; 0 when idle
ack_o  out  N_REQ  one-hot, single-cycle result-valid pulse
y_o  out  WIDTH  registered product, low WIDTH bits
ovf_o  out  1  registered overflow flag of the product
busy_o  out  1  1 in LOAD, RUN, DONE
mul_load_o  out  1  single-cycle load strobe to core
mul_en_o  out  1  core clock enable, high for exactly WIDTH cycles
mul_a_o  out  WIDTH  captured operand A to core
mul_b_o  out  WIDTH  captured operand B to core
mul_y_i  in  WIDTH  core product
mul_ovf_i  in  1  core overflow flag

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE; counter=0; rr_ptr=N_REQ-1; all outputs 0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - eligible = req_i & ~ack_o. The requester being acked this cycle is masked, so a served requester still holding req is never re-granted back-to-back.
  - Round-robin search starts at rr_ptr+1 mod N_REQ.
  - On a hit: latch the winner's a_i/b_i into mul_a_o/mul_b_o, set gnt_o, rr_ptr=winner, go to LOAD.
- LOAD (1 cycle): mul_load_o=1; counter=0; go to RUN.
- RUN:
  - mul_en_o=1; counter increments each cycle.
  - When counter==WIDTH-1, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- DONE (1 cycle):
  - mul_en_o=0.
  - At the edge leaving DONE: y_o<=mul_y_i, ovf_o<=mul_ovf_i, ack_o<=gnt_o, gnt_o<=0, go to IDLE.
- ack_o is high for exactly the one cycle after DONE. y_o/ovf_o hold until the next ack.
- Latency, req first seen at edge 0 with the bus idle:
  - LOAD in cycle 1, RUN in cycles 2..WIDTH+1, DONE in cycle WIDTH+2.
  - ack_o in cycle WIDTH+3 (cycle 19 for WIDTH=16).
  - Back-to-back service repeats every WIDTH+3 cycles.
- Operands are sampled only at grant. Later changes to a_i/b_i, or dropping req_i after grant, do not abort the transaction; ack_o still pulses.
- Requests arriving while busy wait; no queue depth beyond the req level.
- Simultaneous requests: exactly one grant, by round-robin order.
- Reset mid-RUN: transaction discarded, no ack. The core is re-loaded on the next LOAD, so stale core state is irrelevant.
- gnt_o, ack_o: at most one bit set at any time. mul_load_o and mul_en_o are never high in the same cycle.

Optional Feature:
MUL_SHARE_ZERO_SKIP_EN
- Defined:
  - In LOAD, if the captured A==0 or B==0, go directly to DONE with mul_en_o never asserted.
  - y_o<=0 and ovf_o<=0, ignoring mul_y_i/mul_ovf_i.
  - ack_o arrives in cycle 3 after the request is seen.
- Undefined: zero operands take the full WIDTH-cycle RUN path.

Test Plan:
- Reset, then req_i=4'b0001, a=3, b=5 -> gnt_o=0001 in cycles 1..18; mul_en_o high in cycles 2..17 (16 cycles); ack_o=0001 in cycle 19; y_o=15, ovf_o=0.
- a=0x0100, b=0x0100 on requester 2 -> y_o=0x0000, ovf_o=1, ack_o=0100.
- req_i=4'b0101 asserted together and held -> requester 0 acked first; requester 2 granted at the next IDLE (not 0 again); then 0 is served again. Grants alternate 0,2,0,2.
- Requester 1 keeps req high through its ack cycle with no other requesters -> no grant during the ack cycle; re-granted one cycle later.
- rst_i pulsed in cycle 10 of a transaction -> all outputs 0 immediately (asynchronous); no ack_o; a new request afterwards completes normally with a correct product.
- MUL_SHARE_ZERO_SKIP_EN defined, a=0, b=0x1234 -> mul_en_o never high; ack_o in cycle 3; y_o=0. Undefined: ack_o in cycle 19, y_o=0.

Source files
------------

// File: rtl/mul_share_ctrl.sv
// mul_share_ctrl: round-robin sequencer that shares one bit-serial multiplier
// core among N_REQ requesters. The winner's operands are captured at grant,
// loaded into the core, and the core is clock-enabled for exactly WIDTH
// cycles. The registered product is then returned with a one-cycle ack.
//
// Optional feature macro: MUL_SHARE_ZERO_SKIP_EN
//   When defined, a zero operand bypasses RUN and returns y=0, ovf=0.
//
// Ports:
//   clk_i, rst_i        clock (rising edge), async active-high reset
//   req_i               per-requester request level, held until ack
//   a_i, b_i            per-requester operands, slice k = [k*WIDTH +: WIDTH]
//   gnt_o               one-hot current owner of the core
//   ack_o               one-hot single-cycle result-valid pulse
//   y_o, ovf_o          registered product (low WIDTH bits) and overflow
//   busy_o              high in LOAD, RUN, DONE
//   mul_load_o          load strobe to the core
//   mul_en_o            core clock enable, WIDTH cycles per transaction
//   mul_a_o, mul_b_o    captured operands to the core
//   mul_y_i, mul_ovf_i  product and overflow from the core
module mul_share_ctrl #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*WIDTH-1:0] a_i,
  input  logic [N_REQ*WIDTH-1:0] b_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       ack_o,
  output logic [WIDTH-1:0]       y_o,
  output logic                   ovf_o,
  output logic                   busy_o,
  output logic                   mul_load_o,
  output logic                   mul_en_o,
  output logic [WIDTH-1:0]       mul_a_o,
  output logic [WIDTH-1:0]       mul_b_o,
  input  logic [WIDTH-1:0]       mul_y_i,
  input  logic                   mul_ovf_i
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   rr_q, rr_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   ack_q, ack_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               load_q, load_d;
  logic               en_q, en_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;

  logic [N_REQ-1:0]   eligible;
  logic               hit;
  logic [PTR_W-1:0]   win;
  logic [PTR_W-1:0]   cand;
  int unsigned        idx_sum;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rr_q    <= PTR_W'(N_REQ - 1);
      gnt_q   <= '0;
      ack_q   <= '0;
      y_q     <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      load_q  <= 1'b0;
      en_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      y_q     <= y_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      load_q  <= load_d;
      en_q    <= en_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // Round-robin search from rr_q+1; the requester being acked is masked so a
  // held request cannot be re-granted back-to-back
  always_comb begin
    eligible = req_i & ~ack_q;
    hit      = 1'b0;
    win      = '0;
    cand     = '0;
    idx_sum  = 0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx_sum = 32'(rr_q) + i;
      cand    = PTR_W'(idx_sum % N_REQ);
      if (!hit && eligible[cand]) begin
        hit = 1'b1;
        win = cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    ack_d   = '0;
    y_d     = y_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;

    case (state_q)
      S_IDLE: begin
        if (hit) begin
          a_d     = a_i[32'(win)*WIDTH +: WIDTH];
          b_d     = b_i[32'(win)*WIDTH +: WIDTH];
          gnt_d   = N_REQ'(1) << win;
          rr_d    = win;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cnt_d   = '0;
`ifdef MUL_SHARE_ZERO_SKIP_EN
        // Product of a zero operand is known; skip the serial run
        if ((a_q == '0) || (b_q == '0)) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
`else
        state_d = S_RUN;
`endif
      end
      S_RUN: begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        ack_d   = gnt_q;
        gnt_d   = '0;
`ifdef MUL_SHARE_ZERO_SKIP_EN
        if ((a_q == '0) || (b_q == '0)) begin
          y_d   = '0;
          ovf_d = 1'b0;
        end else begin
          y_d   = mul_y_i;
          ovf_d = mul_ovf_i;
        end
`else
        y_d     = mul_y_i;
        ovf_d   = mul_ovf_i;
`endif
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Strobes are registered copies of the next-state decode
    busy_d = (state_d != S_IDLE);
    load_d = (state_d == S_LOAD);
    en_d   = (state_d == S_RUN);
  end

  assign gnt_o      = gnt_q;
  assign ack_o      = ack_q;
  assign y_o        = y_q;
  assign ovf_o      = ovf_q;
  assign busy_o     = busy_q;
  assign mul_load_o = load_q;
  assign mul_en_o   = en_q;
  assign mul_a_o    = a_q;
  assign mul_b_o    = b_q;

endmodule

// File: tb/tb_mul_share_ctrl.sv
// Testbench for mul_share_ctrl: bit-serial core model plus a scoreboard of
// expected (requester, product, overflow, enable-cycle count) per ack.
module tb_mul_share_ctrl;

  localparam int unsigned N = 4;
  localparam int unsigned W = 16;
`ifdef MUL_SHARE_ZERO_SKIP_EN
  localparam int unsigned ZERO_LAT = 3;
`else
  localparam int unsigned ZERO_LAT = W + 3;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] a_i, b_i;
  logic [N-1:0]   gnt_o, ack_o;
  logic [W-1:0]   y_o;
  logic           ovf_o, busy_o, mul_load_o, mul_en_o;
  logic [W-1:0]   mul_a_o, mul_b_o, mul_y_i;
  logic           mul_ovf_i;

  mul_share_ctrl #(.N_REQ(N), .WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req_i), .a_i(a_i), .b_i(b_i),
    .gnt_o(gnt_o), .ack_o(ack_o), .y_o(y_o), .ovf_o(ovf_o), .busy_o(busy_o),
    .mul_load_o(mul_load_o), .mul_en_o(mul_en_o),
    .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_y_i(mul_y_i), .mul_ovf_i(mul_ovf_i)
  );

  always #5 clk = ~clk;

  // Bit-serial shift-add core stand-in
  logic [2*W-1:0] acc;
  logic [W-1:0]   ma, mb;
  logic [4:0]     k;
  always @(posedge clk) begin
    if (mul_load_o) begin
      acc <= '0;
      ma  <= mul_a_o;
      mb  <= mul_b_o;
      k   <= '0;
    end else if (mul_en_o) begin
      if (mb[k[3:0]]) acc <= acc + ({16'h0, ma} << k);
      k <= k + 5'd1;
    end
  end
  assign mul_y_i   = acc[W-1:0];
  assign mul_ovf_i = |acc[2*W-1:W];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  typedef struct {
    logic [N-1:0] who;
    logic [W-1:0] y;
    logic         ovf;
    int           en;
  } exp_t;
  exp_t sb[$];

  task automatic push_exp(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [2*W-1:0] p;
    p     = 32'(a) * 32'(b);
    e.who = N'(1) << idx;
    e.y   = p[W-1:0];
    e.ovf = |p[2*W-1:W];
    e.en  = W;
`ifdef MUL_SHARE_ZERO_SKIP_EN
    if (a == '0 || b == '0) e.en = 0;
`endif
    sb.push_back(e);
  endtask

  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b);
    a_i[idx*W +: W] = a;
    b_i[idx*W +: W] = b;
    req_i[idx]      = 1'b1;
  endtask

  // Bounded wait for an ack; returns at the negedge where it is seen
  task automatic wait_ack(output logic [N-1:0] who);
    who = '0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ack_o != '0) begin
        who = ack_o;
        return;
      end
    end
    check("ack_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: invariants every cycle, scoreboard pop on ack
  int en_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (mul_load_o) en_cnt = 0;
      if (mul_en_o) en_cnt++;
      check("load_en_excl", 32'(mul_load_o & mul_en_o), 32'd0);
      check("gnt_onehot", 32'($countones(gnt_o) <= 1), 32'd1);
      check("ack_onehot", 32'($countones(ack_o) <= 1), 32'd1);
      if (ack_o != '0) begin
        if (sb.size() == 0) begin
          check("unexpected_ack", 32'(ack_o), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_who", 32'(ack_o), 32'(e.who));
          check("sb_y", 32'(y_o), 32'(e.y));
          check("sb_ovf", 32'(ovf_o), 32'(e.ovf));
          check("sb_en_cycles", 32'(en_cnt), 32'(e.en));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N-1:0] who;
    logic [W-1:0] ra, rb;
    int           ri;
    rst   = 1'b1;
    req_i = '0;
    a_i   = '0;
    b_i   = '0;
    repeat (3) @(negedge clk);
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_y", 32'(y_o), 32'd0);
    check("rst_en", 32'(mul_en_o | mul_load_o), 32'd0);
    rst = 1'b0;

    // Single transaction with cycle-exact timing
    @(negedge clk);
    set_req(0, 16'd3, 16'd5);
    push_exp(0, 16'd3, 16'd5);
    for (int n = 1; n <= 19; n++) begin
      @(negedge clk);
      check("t1_gnt", 32'(gnt_o), (n <= 18) ? 32'd1 : 32'd0);
      check("t1_load", 32'(mul_load_o), (n == 1) ? 32'd1 : 32'd0);
      check("t1_en", 32'(mul_en_o), (n >= 2 && n <= 17) ? 32'd1 : 32'd0);
      check("t1_busy", 32'(busy_o), (n <= 18) ? 32'd1 : 32'd0);
      check("t1_ack", 32'(ack_o), (n == 19) ? 32'd1 : 32'd0);
    end
    check("t1_y", 32'(y_o), 32'd15);
    req_i = '0;

    // Overflow case on requester 2
    @(negedge clk);
    set_req(2, 16'h0100, 16'h0100);
    push_exp(2, 16'h0100, 16'h0100);
    wait_ack(who);
    check("t2_who", 32'(who), 32'h4);
    check("t2_ovf", 32'(ovf_o), 32'd1);
    req_i = '0;

    // Contention: 0 and 2 held together alternate 0,2,0,2
    @(negedge clk);
    set_req(0, 16'd100, 16'd200);
    set_req(2, 16'hABCD, 16'd7);
    push_exp(0, 16'd100, 16'd200);
    push_exp(2, 16'hABCD, 16'd7);
    push_exp(0, 16'd100, 16'd200);
    push_exp(2, 16'hABCD, 16'd7);
    wait_ack(who); check("t3_ord0", 32'(who), 32'h1);
    wait_ack(who); check("t3_ord1", 32'(who), 32'h4);
    wait_ack(who); check("t3_ord2", 32'(who), 32'h1);
    req_i[0] = 1'b0;
    wait_ack(who); check("t3_ord3", 32'(who), 32'h4);
    req_i = '0;

    // Held request is masked during its own ack cycle
    @(negedge clk);
    set_req(1, 16'd12, 16'd34);
    push_exp(1, 16'd12, 16'd34);
    push_exp(1, 16'd12, 16'd34);
    wait_ack(who);
    check("t4_who", 32'(who), 32'h2);
    check("t4_gnt_ack_cyc", 32'(gnt_o), 32'd0);
    @(negedge clk);
    check("t4_gnt_next", 32'(gnt_o), 32'd0);
    @(negedge clk);
    check("t4_regrant", 32'(gnt_o), 32'h2);
    wait_ack(who);
    check("t4_who2", 32'(who), 32'h2);
    req_i = '0;

    // Asynchronous reset mid-RUN discards the transaction
    @(negedge clk);
    set_req(0, 16'd7, 16'd9);
    repeat (10) @(negedge clk);
    check("t5_pre_en", 32'(mul_en_o), 32'd1);
    rst = 1'b1;
    #1;
    check("t5_gnt", 32'(gnt_o), 32'd0);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_en", 32'(mul_en_o), 32'd0);
    check("t5_mula", 32'(mul_a_o), 32'd0);
    check("t5_y", 32'(y_o), 32'd0);
    req_i = '0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      check("t5_noack", 32'(ack_o), 32'd0);
    end
    set_req(3, 16'd7, 16'd9);
    push_exp(3, 16'd7, 16'd9);
    wait_ack(who);
    check("t5_who", 32'(who), 32'h8);
    check("t5_y_after", 32'(y_o), 32'd63);
    req_i = '0;

    // Zero operand latency
    @(negedge clk);
    set_req(0, 16'h0000, 16'h1234);
    push_exp(0, 16'h0000, 16'h1234);
    for (int n = 1; n <= int'(ZERO_LAT); n++) begin
      @(negedge clk);
      check("t6_ack", 32'(ack_o), (n == int'(ZERO_LAT)) ? 32'd1 : 32'd0);
    end
    check("t6_y", 32'(y_o), 32'd0);
    req_i = '0;

    // Maximum operands and random single-requester transactions
    @(negedge clk);
    set_req(1, 16'hFFFF, 16'hFFFF);
    push_exp(1, 16'hFFFF, 16'hFFFF);
    wait_ack(who);
    check("t7_max_y", 32'(y_o), 32'h1);
    req_i = '0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      ri = int'($urandom_range(N - 1, 0));
      ra = W'($urandom);
      rb = W'($urandom);
      set_req(ri, ra, rb);
      push_exp(ri, ra, rb);
      wait_ack(who);
      check("t7_who", 32'(who), 32'(N'(1) << ri));
      req_i = '0;
    end

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
